wb_spi_bridge: RTL

WB_SPI_BRIDGE -- requirements
Module: wb_spi_bridge

---
 rtl/wb_spi_bridge_pkg.sv | 25 ++
 rtl/wb_spi_bridge_if.sv | 15 +
 rtl/wb_spi_bridge.sv | 91 +++++++++
 3 files changed

// File: rtl/wb_spi_bridge_pkg.sv
// wb_spi_bridge_pkg: shared register map, FSM encoding and field layout for the Wishbone-to-SPI bridge.
package wb_spi_bridge_pkg;
    localparam logic [1:0] ADR_CONFIG = 2'd0;
    localparam logic [1:0] ADR_TXDATA = 2'd1;
    localparam logic [1:0] ADR_RXDATA = 2'd2;
    localparam logic [1:0] ADR_STATUS = 2'd3;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ERR} state_t;
    localparam int ST_BUSY = 0;
    localparam int ST_RX_EMPTY = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int DIN_BYTE = 0;
    localparam int DIN_START = 8;
    localparam int DIN_STOP = 9;
    localparam int DIN_RX = 10;
    localparam int DIN_MODE = 0;
    localparam int DIN_ENDIAN = 2;
    localparam int DIN_BAUD = 3;
    localparam int DIN_W = DIN_RX + 1;
    function automatic logic [31:0] status_word(logic timeout, logic rx_empty, logic busy);
        status_word = '0;
        status_word[ST_TIMEOUT] = timeout;
        status_word[ST_RX_EMPTY] = rx_empty;
        status_word[ST_BUSY] = busy;
    endfunction
endpackage

// File: rtl/wb_spi_bridge_if.sv
// wb_spi_bridge_if: Wishbone classic slave bus seen by the bridge.
interface wb_spi_bridge_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [1:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    modport master(output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
                   input wb_dat_o, wb_ack_o, wb_err_o);
    modport slave(input wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
                  output wb_dat_o, wb_ack_o, wb_err_o);
endinterface

// File: rtl/wb_spi_bridge.sv
// wb_spi_bridge: turns Wishbone accesses into one-cycle strobes for the SPI interface stage,
// retrying unacknowledged strobes until TIMEOUT and reporting the result as ack or err.
module wb_spi_bridge
    import wb_spi_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    wb_spi_bridge_if.slave      wb,
    output logic [DIN_W-1:0]    if_din,
    output logic                if_cmd,
    output logic                if_wr,
    output logic                if_rd,
    input  logic [8:0]          if_dout,
    input  logic                if_ack
);
    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [1:0]  adr_q;
    logic        we_q;
    logic [8:0]  rdata;
    logic        timeout_q;
    logic        busy_q;
    logic        req, legal, accept, unused_ok;

    assign req = wb.wb_cyc_i & wb.wb_stb_i;
    assign legal = wb.wb_we_i ? (wb.wb_adr_i == ADR_CONFIG || wb.wb_adr_i == ADR_TXDATA)
                              : (wb.wb_adr_i == ADR_RXDATA);
    assign accept = state == S_IDLE && req;
    assign unused_ok = ^wb.wb_dat_i[31:DIN_W];

    always_comb begin
        state_nxt = state;
        if_cmd = 1'b0;
        if_wr = 1'b0;
        if_rd = 1'b0;
        wb.wb_ack_o = 1'b0;
        wb.wb_err_o = 1'b0;
        wb.wb_dat_o = '0;
        case (state)
            S_IDLE: state_nxt = !req ? S_IDLE : wb.wb_adr_i == ADR_STATUS ? S_RESP : legal ? S_ISSUE : S_ERR;
            S_ISSUE: begin
                if_cmd = adr_q == ADR_CONFIG && we_q;
                if_wr = adr_q == ADR_TXDATA && we_q;
                if_rd = adr_q == ADR_RXDATA && !we_q;
                state_nxt = wb.wb_cyc_i ? S_WAIT : S_IDLE;
            end
            // A missing ack means the downstream stage could not take the strobe (e.g. TX FIFO full): retry it.
            S_WAIT: state_nxt = !wb.wb_cyc_i ? S_IDLE : if_ack ? S_RESP : cnt == 8'(TIMEOUT) ? S_ERR : S_ISSUE;
            S_RESP: begin
                wb.wb_ack_o = req;
                wb.wb_dat_o = !req || we_q ? '0 : adr_q == ADR_STATUS ? status_word(timeout_q, rdata[8], busy_q) : {23'b0, rdata};
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                wb.wb_err_o = req;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt <= '0;
            adr_q <= '0;
            we_q <= 1'b0;
            if_din <= '0;
            rdata <= 9'h100;
            timeout_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) cnt <= '0;
            else if (state == S_WAIT && state_nxt == S_ISSUE && cnt != 8'hff) cnt <= cnt + 8'd1;
            if (accept) begin
                adr_q <= wb.wb_adr_i;
                we_q <= wb.wb_we_i;
            end
            if (accept && state_nxt == S_ISSUE) if_din <= wb.wb_dat_i[DIN_W-1:0];
            if (if_rd) rdata <= if_dout;
            if (state == S_ERR) timeout_q <= 1'b1;
            else if (accept && wb.wb_we_i && wb.wb_adr_i == ADR_STATUS && wb.wb_dat_i[ST_TIMEOUT]) timeout_q <= 1'b0;
            // Busy tracks a strobe the downstream stage has not yet acknowledged, even after an abort.
            if (if_cmd || if_wr || if_rd) busy_q <= 1'b1;
            else if (if_ack) busy_q <= 1'b0;
        end
    end
endmodule
